// File: rtl/xcorr_frame_ctrl.sv
// xcorr_frame_ctrl
//   Frame sequencer for a two-microphone cross-correlator. Captures N sample
//   pairs into two dual-port RAMs, streams them back out (one read per cycle)
//   to the xcorr engine, then waits for the engine to report completion.
//
//   Flow: IDLE -> CAPTURE -> READ -> WAIT -> DONE -> (CAPTURE | IDLE)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   xc_en                 run frames continuously while high
//   smp_valid, smp0/1     incoming sample pair strobe and data
//   ram_wea/addra/dina*   capture RAM write port (combinational, same cycle)
//   ram_ceb/addrb         capture RAM read port (1-cycle latency RAM)
//   xc_start              one-cycle pulse on the first read of a frame
//   xc_res_valid, xc_res  xcorr result stream (used by the peak tracker)
//   xc_done               engine finished the frame
//   frame_done, frame_cnt completed-frame pulse and wrapping counter
//   busy                  high whenever not IDLE
//   err_tmo               sticky: engine never answered within TMO cycles
//   peak_lag, peak_val    lag/value of the largest result of the last frame
//
// Build option
//   XCORR_PEAK_EN         enables the peak tracker; otherwise peak_* read 0.

module xcorr_frame_ctrl #(
    parameter int W   = 16,
    parameter int N   = 512,
    parameter int AW  = 9,
    parameter int RW  = 40,
    parameter int TMO = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 xc_en,
    input  logic                 smp_valid,
    input  logic signed [W-1:0]  smp0,
    input  logic signed [W-1:0]  smp1,
    output logic                 ram_wea,
    output logic [AW-1:0]        ram_addra,
    output logic [W-1:0]         ram_dina0,
    output logic [W-1:0]         ram_dina1,
    output logic                 ram_ceb,
    output logic [AW-1:0]        ram_addrb,
    output logic                 xc_start,
    input  logic                 xc_res_valid,
    input  logic signed [RW-1:0] xc_res,
    input  logic                 xc_done,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt,
    output logic                 busy,
    output logic                 err_tmo,
    output logic [AW:0]          peak_lag,
    output logic signed [RW-1:0] peak_val
);

    localparam int            TW   = $clog2(TMO + 1);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          cap_wr;

    // Writes go out in the same cycle as the strobe. An abort (xc_en low)
    // takes priority over a coincident sample so nothing lands in the RAM
    // after the frame has been abandoned.
    assign cap_wr    = (state == S_CAPTURE) && xc_en && smp_valid;
    assign ram_wea   = cap_wr;
    assign ram_addra = wr_cnt;
    assign ram_dina0 = cap_wr ? smp0 : '0;
    assign ram_dina1 = cap_wr ? smp1 : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_cnt     <= '0;
            tmo_cnt    <= '0;
            ram_ceb    <= 1'b0;
            ram_addrb  <= '0;
            xc_start   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_tmo    <= 1'b0;
        end else begin
            xc_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xc_en) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!xc_en) begin
                        state  <= S_IDLE;
                        wr_cnt <= '0;
                    end else if (smp_valid) begin
                        if (wr_cnt == LAST) begin
                            // Last write: arm the read burst so the first
                            // read and xc_start appear on the next cycle.
                            wr_cnt    <= '0;
                            state     <= S_READ;
                            ram_ceb   <= 1'b1;
                            ram_addrb <= '0;
                            xc_start  <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (ram_addrb == LAST) begin
                        state     <= S_WAIT;
                        ram_ceb   <= 1'b0;
                        ram_addrb <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        ram_addrb <= ram_addrb + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (xc_done) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        state   <= S_IDLE;
                        err_tmo <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= xc_en ? S_CAPTURE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef XCORR_PEAK_EN
    logic                 trk_on;
    logic                 trk_first;
    logic                 trk_upd;
    logic [AW:0]          trk_cnt;
    logic [AW:0]          trk_lag;
    logic signed [RW-1:0] trk_val;
    logic [AW:0]          nxt_lag;
    logic signed [RW-1:0] nxt_val;

    // Results are only meaningful once the read burst has started. The
    // running max is exposed as nxt_* so a strobe coinciding with xc_done
    // still makes it into the published peak.
    assign trk_on  = (state == S_READ) || (state == S_WAIT);
    assign trk_upd = trk_on && xc_res_valid && (trk_first || (xc_res > trk_val));
    assign nxt_lag = trk_upd ? trk_cnt : trk_lag;
    assign nxt_val = trk_upd ? xc_res : trk_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_first <= 1'b1;
            trk_cnt   <= '0;
            trk_lag   <= '0;
            trk_val   <= '0;
        end else if (!trk_on) begin
            trk_first <= 1'b1;
            trk_cnt   <= '0;
            trk_lag   <= '0;
            trk_val   <= '0;
        end else if (xc_res_valid) begin
            trk_first <= 1'b0;
            trk_cnt   <= trk_cnt + 1'b1;
            trk_lag   <= nxt_lag;
            trk_val   <= nxt_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_lag <= '0;
            peak_val <= '0;
        end else if (state == S_WAIT && xc_done) begin
            peak_lag <= nxt_lag;
            peak_val <= nxt_val;
        end
    end
`else
    logic unused_res;
    assign unused_res = ^{xc_res_valid, xc_res};
    assign peak_lag   = '0;
    assign peak_val   = '0;
`endif

endmodule

// File: tb/tb_xcorr_frame_ctrl.sv
module tb_xcorr_frame_ctrl;
    localparam int W = 16, N = 512, AW = 9, RW = 40, TMO = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic xc_en = 1'b0, smp_valid = 1'b0, xc_res_valid = 1'b0, xc_done = 1'b0;
    logic signed [W-1:0]  smp0 = '0, smp1 = '0;
    logic signed [RW-1:0] xc_res = '0;
    logic                 ram_wea, ram_ceb, xc_start, frame_done, busy, err_tmo;
    logic [AW-1:0]        ram_addra, ram_addrb;
    logic [W-1:0]         ram_dina0, ram_dina1;
    logic [15:0]          frame_cnt;
    logic [AW:0]          peak_lag;
    logic signed [RW-1:0] peak_val;

    int checks = 0;
    int errors = 0;
    logic [15:0]          exp_cnt = '0;
    logic [AW:0]          exp_lag = '0;
    logic signed [RW-1:0] exp_val = '0;
    logic signed [RW-1:0] res [2*N-1];

    xcorr_frame_ctrl #(.W(W), .N(N), .AW(AW), .RW(RW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .xc_en(xc_en), .smp_valid(smp_valid),
        .smp0(smp0), .smp1(smp1), .ram_wea(ram_wea), .ram_addra(ram_addra),
        .ram_dina0(ram_dina0), .ram_dina1(ram_dina1), .ram_ceb(ram_ceb),
        .ram_addrb(ram_addrb), .xc_start(xc_start), .xc_res_valid(xc_res_valid),
        .xc_res(xc_res), .xc_done(xc_done), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .busy(busy), .err_tmo(err_tmo),
        .peak_lag(peak_lag), .peak_val(peak_val)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; xc_en = 1'b1; smp_valid = 1'b1; smp0 = 16'sh1234; smp1 = -16'sd5;
        xc_done = 1'b1; xc_res_valid = 1'b1; xc_res = 40'sd77;
        repeat (3) step();
        #1;
        checks++;
        if ({ram_wea, ram_ceb, xc_start, frame_done, busy, err_tmo} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {ram_wea, ram_ceb, xc_start, frame_done, busy, err_tmo});
        end
        checks++;
        if (ram_addra !== '0 || ram_addrb !== '0 || ram_dina0 !== '0 || ram_dina1 !== '0) begin
            errors++;
            $display("FAIL reset_ram got addra=%0d addrb=%0d d0=%h d1=%h want all 0", ram_addra, ram_addrb, ram_dina0, ram_dina1);
        end
        checks++;
        if (frame_cnt !== 16'd0 || peak_lag !== '0 || peak_val !== '0) begin
            errors++;
            $display("FAIL reset_counts got cnt=%0d lag=%0d val=%0d want 0", frame_cnt, peak_lag, peak_val);
        end
        xc_en = 1'b0; smp_valid = 1'b0; xc_done = 1'b0; xc_res_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        #1;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b frame_done=%b want 0 0", busy, frame_done);
        end
        exp_cnt = '0; exp_lag = '0; exp_val = '0;
    endtask

    // Feeds n_smp sample pairs, optionally starting from IDLE, with random
    // idle gaps; checks every cycle's RAM write port against the stimulus.
    task automatic capture(input bit from_idle, input int n_smp, input bit pat, input int gap_max);
        int bad, first_bad, g;
        logic signed [W-1:0] s0, s1;
        bad = 0; first_bad = -1;
        if (from_idle) begin
            step();
            xc_en = 1'b1; smp_valid = 1'b1; smp0 = 16'sh7fff; smp1 = 16'sd1;
            xc_done = 1'b0; xc_res_valid = 1'b0;
            #1;
            checks++;
            if (ram_wea !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore got wea=%b busy=%b want 0 0", ram_wea, busy);
            end
        end
        for (int i = 0; i < n_smp; i++) begin
            g = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
            for (int k = 0; k < g; k++) begin
                step();
                smp_valid = 1'b0; smp0 = W'($urandom); smp1 = W'($urandom);
                xc_done = 1'($urandom_range(1, 0));
                xc_res_valid = 1'b1; xc_res = 40'sh7f_ffff_ffff;
                #1;
                if (ram_wea !== 1'b0 || busy !== 1'b1 || ram_ceb !== 1'b0 || frame_done !== 1'b0) begin
                    if (bad == 0) first_bad = i;
                    bad++;
                end
            end
            s0 = pat ? W'(i) : W'($urandom);
            s1 = pat ? -s0 : W'($urandom);
            step();
            smp_valid = 1'b1; smp0 = s0; smp1 = s1;
            xc_done = 1'($urandom_range(1, 0)); xc_res_valid = 1'b0;
            #1;
            if (ram_wea !== 1'b1 || ram_addra !== AW'(i) || ram_dina0 !== s0 || ram_dina1 !== s1 ||
                busy !== 1'b1 || ram_ceb !== 1'b0 || frame_done !== 1'b0) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL capture_writes got %0d bad cycles (first at sample %0d) want 0", bad, first_bad);
        end
    endtask

    // Runs READ and WAIT of a captured frame through DONE; optionally feeds a
    // 2N-1 result stream and checks the published peak against a plain max.
    task automatic read_wait(input bit strobes, input bit peak_pat, input bit drop_en);
        int done_t, bad, ceb_n, start_n, a, b, first_bad;
        logic [63:0] r;
        logic [AW:0] m_lag, e_lag;
        logic signed [RW-1:0] m_val, e_val;
        m_lag = '0; m_val = '0;
        if (strobes) begin
            for (int j = 0; j < 2*N-1; j++) begin
                if (peak_pat) res[j] = RW'($urandom_range(5999, 0)) - RW'(5000);
                else begin r = {$urandom, $urandom}; res[j] = r[RW-1:0]; end
            end
            if (peak_pat) begin
                res[300] = 40'sd1000; res[700] = 40'sd1000;
            end else begin
                a = 0;
                for (int j = 1; j < 2*N-1; j++) if (res[j] > res[a]) a = j;
                if (a < 2*N-2) begin
                    b = int'($urandom_range(2*N-2, a+1));
                    res[b] = res[a];
                end
            end
            m_val = res[0]; m_lag = '0;
            for (int j = 1; j < 2*N-1; j++)
                if (res[j] > m_val) begin m_val = res[j]; m_lag = (AW+1)'(j); end
        end
`ifdef XCORR_PEAK_EN
        e_lag = m_lag; e_val = m_val;
`else
        e_lag = '0; e_val = '0;
`endif
        done_t = strobes ? (2*N-1) + 10 : (N-1) + 10;
        bad = 0; ceb_n = 0; start_n = 0; first_bad = -1;
        for (int t = 0; t <= done_t + 2; t++) begin
            step();
            smp_valid = (t >= done_t + 2) ? 1'b0 : 1'($urandom_range(1, 0));
            smp0 = W'($urandom); smp1 = W'($urandom);
            xc_done = (t == done_t) ? 1'b1 : ((t < N) ? 1'($urandom_range(1, 0)) : 1'b0);
            xc_res_valid = strobes && t >= 1 && t <= 2*N-1;
            if (xc_res_valid) xc_res = res[t-1];
            else xc_res = 40'sh7f_ffff_ffff;
            if (drop_en && t == 5) xc_en = 1'b0;
            #1;
            if (t < N) begin
                if (ram_ceb === 1'b1) ceb_n++;
                if (ram_ceb !== 1'b1 || ram_addrb !== AW'(t)) begin if (bad == 0) first_bad = t; bad++; end
            end else if (ram_ceb !== 1'b0) begin
                if (bad == 0) first_bad = t; bad++;
            end
            if (xc_start === 1'b1) begin
                start_n++;
                if (t != 0) begin if (bad == 0) first_bad = t; bad++; end
            end
            if (ram_wea !== 1'b0) begin if (bad == 0) first_bad = t; bad++; end
            if (t <= done_t && (frame_done !== 1'b0 || busy !== 1'b1 ||
                                peak_lag !== exp_lag || peak_val !== exp_val)) begin
                if (bad == 0) first_bad = t; bad++;
            end
            if (t == done_t + 1) begin
                checks++;
                if (frame_done !== 1'b1) begin
                    errors++; $display("FAIL frame_done_pulse got %b want 1", frame_done);
                end
                checks++;
                if (frame_cnt !== exp_cnt + 16'd1) begin
                    errors++; $display("FAIL frame_cnt got %0d want %0d", frame_cnt, exp_cnt + 16'd1);
                end
                checks++;
                if (peak_lag !== e_lag || peak_val !== e_val) begin
                    errors++;
                    $display("FAIL peak got lag=%0d val=%0d want lag=%0d val=%0d", peak_lag, peak_val, e_lag, e_val);
                end
            end
            if (t == done_t + 2) begin
                checks++;
                if (frame_done !== 1'b0 || busy !== xc_en) begin
                    errors++;
                    $display("FAIL after_done got frame_done=%b busy=%b want 0 %b", frame_done, busy, xc_en);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL read_seq got %0d bad cycles (first t=%0d) want 0", bad, first_bad);
        end
        checks++;
        if (ceb_n !== N || start_n !== 1) begin
            errors++; $display("FAIL read_counts got ceb=%0d start=%0d want %0d 1", ceb_n, start_n, N);
        end
        exp_cnt = exp_cnt + 16'd1; exp_lag = e_lag; exp_val = e_val;
    endtask

    task automatic test_frame_basic();
        capture(1'b1, N, 1'b1, 0);
        read_wait(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        capture(1'b0, N, 1'b0, 3);
        read_wait(1'b1, 1'b0, 1'b0);
        capture(1'b0, N, 1'b0, 2);
        read_wait(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        int bad;
        capture(1'b1, 100, 1'b0, 2);
        step();
        xc_en = 1'b0; smp_valid = 1'b0; xc_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_last_capture got busy=%b want 1", busy); end
        bad = 0;
        for (int t = 0; t < 600; t++) begin
            step();
            smp_valid = 1'($urandom_range(1, 0)); smp0 = W'($urandom);
            xc_done = 1'($urandom_range(1, 0)); xc_res_valid = 1'($urandom_range(1, 0));
            #1;
            if (busy !== 1'b0 || ram_ceb !== 1'b0 || ram_wea !== 1'b0 || frame_done !== 1'b0 ||
                xc_start !== 1'b0 || frame_cnt !== exp_cnt) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_idle got %0d bad cycles want 0", bad); end
        capture(1'b1, N, 1'b1, 0);
        read_wait(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        int bad;
        capture(1'b1, N, 1'b0, 0);
        bad = 0;
        for (int t = 0; t <= N + TMO + 1; t++) begin
            step();
            smp_valid = 1'($urandom_range(1, 0)); xc_done = 1'b0; xc_res_valid = 1'b0;
            if (t == N + TMO) xc_en = 1'b0;
            #1;
            if (t < N + TMO && (err_tmo !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0)) bad++;
            if (t == N + TMO) begin
                checks++;
                if (err_tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", err_tmo); end
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", busy); end
            end
            if (t == N + TMO + 1) begin
                checks++;
                if (frame_cnt !== exp_cnt || frame_done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_after got cnt=%0d fd=%b busy=%b want %0d 0 0", frame_cnt, frame_done, busy, exp_cnt);
                end
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL tmo_wait got %0d bad cycles want 0", bad); end
        capture(1'b1, N, 1'b1, 1);
        read_wait(1'b0, 1'b0, 1'b0);
        checks++;
        if (err_tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", err_tmo); end
    endtask

    task automatic test_reset_mid_read();
        int bad;
        capture(1'b0, N, 1'b0, 1);
        for (int t = 0; t < 50; t++) begin
            step(); smp_valid = 1'b0; xc_done = 1'b0; xc_res_valid = 1'b0;
        end
        step();
        #2;
        checks++;
        if (ram_ceb !== 1'b1) begin errors++; $display("FAIL mid_read_pre got ceb=%b want 1", ram_ceb); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_ceb !== 1'b0 || busy !== 1'b0 || xc_start !== 1'b0 || ram_addrb !== '0) begin
            errors++;
            $display("FAIL rst_read got ceb=%b busy=%b start=%b addrb=%0d want 0", ram_ceb, busy, xc_start, ram_addrb);
        end
        checks++;
        if (frame_cnt !== 16'd0 || err_tmo !== 1'b0 || peak_lag !== '0 || peak_val !== '0) begin
            errors++;
            $display("FAIL rst_counts got cnt=%0d tmo=%b lag=%0d val=%0d want 0", frame_cnt, err_tmo, peak_lag, peak_val);
        end
        xc_en = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = '0;
        bad = 0;
        for (int t = 0; t < 200; t++) begin
            step();
            xc_done = 1'($urandom_range(1, 0)); smp_valid = 1'($urandom_range(1, 0));
            #1;
            if (frame_done !== 1'b0 || ram_ceb !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_cnt) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_release got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xcorr_frame_ctrl.md
XCORR_FRAME_CTRL -- requirements
Module: xcorr_frame_ctrl

Interface
REQ-001 Parameter W, 16, mic sample width in bits.
REQ-002 Parameter N, 512, samples per frame per mic (power of two).
REQ-003 Parameter AW, 9, RAM address width, log2(N).
REQ-004 Parameter RW, 40, xcorr result width in bits.
REQ-005 Parameter TMO, 4096, cycles allowed in WAIT before timeout.
REQ-006 clk  in  1  system clock (60 MHz domain).
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 xc_en  in  1  level, already synchronized; high = run frames continuously.
REQ-009 smp_valid  in  1  one-cycle strobe, new sample pair on smp0/smp1.
REQ-010 smp0, smp1  in  W  signed samples, mic0 and mic1.
REQ-011 ram_wea  out  1  write enable, both capture RAMs.
REQ-012 ram_addra  out  AW  write address.
REQ-013 ram_dina0, ram_dina1  out  W  write data, RAM0 and RAM1.
REQ-014 ram_ceb  out  1  read enable, both RAMs (1-cycle read latency).
REQ-015 ram_addrb  out  AW  read address.
REQ-016 xc_start  out  1  one-cycle pulse, start of xcorr frame.
REQ-017 xc_res_valid  in  1  xcorr result strobe (complete).
REQ-018 xc_res  in  RW  signed xcorr result.
REQ-019 xc_done  in  1  one-cycle pulse, xcorr finished frame.
REQ-020 frame_done  out  1  one-cycle pulse per completed frame.
REQ-021 frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-022 busy  out  1  high in any state except IDLE.
REQ-023 err_tmo  out  1  sticky timeout flag.
REQ-024 peak_lag  out  AW+1  lag index of max result (XCORR_PEAK_EN only).
REQ-025 peak_val  out  RW  max result value (XCORR_PEAK_EN only).

Function
REQ-026 States IDLE, CAPTURE, READ, WAIT, DONE; IDLE->CAPTURE when xc_en=1.
REQ-027 CAPTURE: each smp_valid -> ram_wea=1 same cycle, ram_addra=wr_cnt, dina=smp0/smp1; wr_cnt increments.
REQ-028 CAPTURE->READ on write of address N-1; wr_cnt wraps to 0.
REQ-029 READ: ram_ceb=1 for exactly N consecutive cycles, ram_addrb 0..N-1; xc_start pulses in first ceb cycle.
REQ-030 READ->WAIT after address N-1 issued; WAIT->DONE on xc_done.
REQ-031 DONE lasts one cycle: frame_done=1, frame_cnt+1; then CAPTURE if xc_en=1 else IDLE.
REQ-032 xc_en low in CAPTURE: abort, wr_cnt cleared, IDLE next cycle, no frame_done.
REQ-033 xc_en low in READ/WAIT: frame completes normally, then IDLE.
REQ-034 smp_valid outside CAPTURE ignored; no RAM write.
REQ-035 WAIT counter reaches TMO without xc_done: err_tmo=1, go IDLE, no frame_done; err_tmo cleared only by reset.
REQ-036 xc_done outside WAIT ignored.

Reset
REQ-037 rst_n low: state IDLE, all counters 0, all outputs 0 (peak_val 0, peak_lag 0), within the same cycle, independent of clk.
REQ-038 Reset mid-frame discards frame; no partial frame_done after release.

Configuration
REQ-039 Macro XCORR_PEAK_EN defined: peak tracker on xc_res_valid stream; lag index counts 0..2N-2 from first strobe after xc_start.
REQ-040 Tracker updates on strict signed greater-than only (ties keep earliest lag); the first strobe loads unconditionally.
REQ-041 peak_lag/peak_val registered, updated at DONE, held until next DONE.
REQ-042 Macro undefined: tracker absent, peak_lag and peak_val tied to 0.

Verification
REQ-043 xc_en=1, 512 smp_valid with smp0=i, smp1=-i -> RAM addr 0..511 written, then 512 ceb cycles addrb 0..511, one xc_start.
REQ-044 xc_done 10 cycles after last ceb -> frame_done one cycle, frame_cnt=1, CAPTURE re-entered.
REQ-045 xc_en dropped after 100 samples -> IDLE, no ram_ceb, frame_cnt unchanged.
REQ-046 No xc_done -> err_tmo=1 exactly TMO cycles after WAIT entry, busy=0 next cycle.
REQ-047 XCORR_PEAK_EN, 1023 results with max 1000 at lags 300 and 700 -> peak_lag=300, peak_val=1000.
REQ-048 rst_n low mid-READ -> ram_ceb=0 immediately, state IDLE, frame_cnt=0.
